// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: collects NCH serial samples per frame into one wide word.
// Optional even-parity checking on each accepted beat is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
   parameter int W   = 8,
   parameter int NCH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     d,
   input  logic             d_valid,
   input  logic             frame_start,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic             par,
`endif
   output logic [NCH*W-1:0] z,
   output logic             z_valid,
   output logic             sync_err
);

   localparam int SW = $clog2(NCH);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

   typedef enum logic {
      HUNT,
      RECV
   } state_t;

   state_t          state;
   logic [SW-1:0]   slot;
   logic [W-1:0]    shadow [NCH];
   logic [NCH*W-1:0] frame_word;
   logic            par_bad;

`ifdef TDM_DEMUX_PARITY_EN
   assign par_bad = ^{d, par};
`else
   assign par_bad = 1'b0;
`endif

   // The last sample bypasses shadow storage so z loads on the same edge that accepts it.
   always_comb begin
      frame_word = '0;
      for (int k = 0; k < NCH - 1; k++) begin
         frame_word[k*W +: W] = shadow[k];
      end
      frame_word[(NCH-1)*W +: W] = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         slot     <= '0;
         z        <= '0;
         z_valid  <= 1'b0;
         sync_err <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            shadow[k] <= '0;
         end
      end else begin
         z_valid  <= 1'b0;
         sync_err <= 1'b0;
         if (d_valid) begin
            // A corrupted beat is never stored, even if it claims to start a frame.
            if (par_bad) begin
               sync_err <= 1'b1;
               state    <= HUNT;
               slot     <= '0;
            end else if (frame_start) begin
               if (state == RECV) begin
                  sync_err <= 1'b1;
               end
               shadow[0] <= d;
               slot      <= SW'(1);
               state     <= RECV;
            end else if (state == RECV) begin
               shadow[slot] <= d;
               if (slot == LAST_SLOT) begin
                  z       <= frame_word;
                  z_valid <= 1'b1;
                  state   <= HUNT;
                  slot    <= '0;
               end else begin
                  slot <= slot + SW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (W=8, NCH=4): directed vector table, multi-cycle sequences and
// randomized beats against a queue-based frame model. Parity cases build with TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;

   localparam int W   = 8;
   localparam int NCH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [W-1:0]     d;
   logic             d_valid;
   logic             frame_start;
`ifdef TDM_DEMUX_PARITY_EN
   logic             par;
`endif
   logic [NCH*W-1:0] z;
   logic             z_valid;
   logic             sync_err;

   int checks   = 0;
   int failures = 0;

   // Reference model: the samples of the frame in progress (empty means hunting).
   logic [W-1:0]     mq [$];
   logic [NCH*W-1:0] m_z  = '0;
   bit               m_zv = 1'b0;
   bit               m_se = 1'b0;

   typedef struct {
      logic [W-1:0]     d;
      bit               dv;
      bit               fs;
      bit               ezv;
      bit               ese;
      logic [NCH*W-1:0] ez;
   } vec_t;

   vec_t tbl [22];

   tdm_demux #(.W(W), .NCH(NCH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d           (d),
      .d_valid     (d_valid),
      .frame_start (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
      .par         (par),
`endif
      .z           (z),
      .z_valid     (z_valid),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [W-1:0] dd, input bit dv, input bit fs,
                               input bit ezv, input bit ese, input logic [NCH*W-1:0] ez);
      vec_t v;
      v.d = dd; v.dv = dv; v.fs = fs; v.ezv = ezv; v.ese = ese; v.ez = ez;
      return v;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_z  = '0;
      m_zv = 1'b0;
      m_se = 1'b0;
   endtask

   task automatic modelBeat(input logic [W-1:0] dd, input bit dv, input bit fs, input bit bad);
      m_zv = 1'b0;
      m_se = 1'b0;
      if (!dv) return;
      if (bad) begin
         m_se = 1'b1;
         mq.delete();
      end else if (fs) begin
         if (mq.size() != 0) m_se = 1'b1;
         mq.delete();
         mq.push_back(dd);
      end else if (mq.size() != 0) begin
         mq.push_back(dd);
         if (mq.size() == NCH) begin
            for (int k = 0; k < NCH; k++) m_z[k*W +: W] = mq[k];
            m_zv = 1'b1;
            mq.delete();
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model, and settle just after the edge.
   task automatic applyStimulus(input logic [W-1:0] dd, input bit dv, input bit fs, input bit bad);
      d           = dd;
      d_valid     = dv;
      frame_start = fs;
`ifdef TDM_DEMUX_PARITY_EN
      par         = (^dd) ^ bad;
`endif
      modelBeat(dd, dv, fs, bad);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input bit ezv, input bit ese,
                              input logic [NCH*W-1:0] ez);
      checks++;
      if (z_valid !== ezv) begin
         failures++;
         $display("[TB] FAIL %s z_valid got=%b want=%b", name, z_valid, ezv);
      end
      checks++;
      if (sync_err !== ese) begin
         failures++;
         $display("[TB] FAIL %s sync_err got=%b want=%b", name, sync_err, ese);
      end
      checks++;
      if (z !== ez) begin
         failures++;
         $display("[TB] FAIL %s z got=%h want=%h", name, z, ez);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog z_valid=%b sync_err=%b z=%h", z_valid, sync_err, z);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      d           = '0;
      d_valid     = 1'b0;
      frame_start = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par         = 1'b0;
`endif
      modelReset();
      #1;
      checkOutput("reset_state", 1'b0, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      tbl[0]  = mk(8'h11, 1, 1, 0, 0, 32'h0);
      tbl[1]  = mk(8'h22, 1, 0, 0, 0, 32'h0);
      tbl[2]  = mk(8'h33, 1, 0, 0, 0, 32'h0);
      tbl[3]  = mk(8'h44, 1, 0, 1, 0, 32'h44332211);
      tbl[4]  = mk(8'h00, 0, 0, 0, 0, 32'h44332211);
      tbl[5]  = mk(8'hAA, 1, 1, 0, 0, 32'h44332211);
      tbl[6]  = mk(8'hBB, 1, 0, 0, 0, 32'h44332211);
      tbl[7]  = mk(8'h01, 1, 1, 0, 1, 32'h44332211);
      tbl[8]  = mk(8'h02, 1, 0, 0, 0, 32'h44332211);
      tbl[9]  = mk(8'h03, 1, 0, 0, 0, 32'h44332211);
      tbl[10] = mk(8'h04, 1, 0, 1, 0, 32'h04030201);
      tbl[11] = mk(8'h55, 1, 0, 0, 0, 32'h04030201);
      tbl[12] = mk(8'h55, 1, 0, 0, 0, 32'h04030201);
      tbl[13] = mk(8'hA1, 1, 1, 0, 0, 32'h04030201);
      tbl[14] = mk(8'hA2, 1, 0, 0, 0, 32'h04030201);
      tbl[15] = mk(8'hA3, 1, 0, 0, 0, 32'h04030201);
      tbl[16] = mk(8'hA4, 1, 0, 1, 0, 32'hA4A3A2A1);
      tbl[17] = mk(8'hB1, 1, 1, 0, 0, 32'hA4A3A2A1);
      tbl[18] = mk(8'hB2, 1, 0, 0, 0, 32'hA4A3A2A1);
      tbl[19] = mk(8'hB3, 1, 0, 0, 0, 32'hA4A3A2A1);
      tbl[20] = mk(8'hB4, 1, 0, 1, 0, 32'hB4B3B2B1);
      tbl[21] = mk(8'hC1, 0, 1, 0, 0, 32'hB4B3B2B1);

      for (int i = 0; i < 22; i++) begin
         applyStimulus(tbl[i].d, tbl[i].dv, tbl[i].fs, 1'b0);
         checkOutput($sformatf("vec%0d", i), tbl[i].ezv, tbl[i].ese, tbl[i].ez);
      end

      // Frame with three idle cycles between every beat.
      for (int b = 0; b < NCH; b++) begin
         logic [W-1:0] sample;
         sample = W'((b + 1) * 8'h11);
         applyStimulus(sample, 1'b1, b == 0, 1'b0);
         if (b == NCH - 1) checkOutput("gap_done", 1'b1, 1'b0, 32'h44332211);
         else              checkOutput("gap_beat", 1'b0, 1'b0, 32'hB4B3B2B1);
         for (int g = 0; g < 3; g++) begin
            applyStimulus(8'hEE, 1'b0, 1'b0, 1'b0);
            checkOutput("gap_idle", 1'b0, 1'b0, (b == NCH - 1) ? 32'h44332211 : 32'hB4B3B2B1);
         end
      end

      // Reset after slot 2, then a clean frame.
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset", 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
      checkOutput("post_reset_stray", 1'b0, 1'b0, '0);
      for (int b = 0; b < NCH; b++) begin
         applyStimulus(W'(b + 1), 1'b1, b == 0, 1'b0);
      end
      checkOutput("post_reset_frame", 1'b1, 1'b0, 32'h04030201);

`ifdef TDM_DEMUX_PARITY_EN
      applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b1);
      checkOutput("par_bad", 1'b0, 1'b1, 32'h04030201);
      applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
      checkOutput("par_hunt", 1'b0, 1'b0, 32'h04030201);
      applyStimulus(8'h0A, 1'b1, 1'b1, 1'b1);
      checkOutput("par_bad_fs", 1'b0, 1'b1, 32'h04030201);
      applyStimulus(8'h0B, 1'b1, 1'b0, 1'b0);
      checkOutput("par_bad_fs_dropped", 1'b0, 1'b0, 32'h04030201);
      for (int b = 0; b < NCH; b++) begin
         applyStimulus(W'(8'h0A + b), 1'b1, b == 0, 1'b0);
      end
      checkOutput("par_recover", 1'b1, 1'b0, 32'h0D0C0B0A);
`endif

      for (int i = 0; i < 600; i++) begin
         bit dv, fs, bad;
         dv  = $urandom_range(0, 3) != 0;
         fs  = $urandom_range(0, 4) == 0;
`ifdef TDM_DEMUX_PARITY_EN
         bad = $urandom_range(0, 15) == 0;
`else
         bad = 1'b0;
`endif
         applyStimulus(W'($urandom), dv, fs, bad);
         checkOutput("rand", m_zv, m_se, m_z);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter W, default 8: sample width in bits.
REQ-002 Parameter NCH, default 4, legal range 2..16: number of time slots per frame.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 d  input  W  serial sample for the current slot.
REQ-006 d_valid  input  1  d is valid this cycle; a beat is accepted when d_valid=1.
REQ-007 frame_start  input  1  qualified by d_valid; marks the beat as slot 0.
REQ-008 par  input  1  even parity over d; this port SHALL exist only when TDM_DEMUX_PARITY_EN is defined.
REQ-009 z  output  NCH*W  demultiplexed frame; channel k SHALL occupy bits [k*W +: W].
REQ-010 z_valid  output  1  one-cycle pulse: z was updated on this cycle's preceding edge.
REQ-011 sync_err  output  1  one-cycle pulse: a frame was aborted.

Function
REQ-012 The FSM SHALL have two states: HUNT (no frame in progress) and RECV (slot counter 1..NCH-1 expected next).
REQ-013 In HUNT, a beat with frame_start=0 SHALL be discarded with no error.
REQ-014 In HUNT, a beat with frame_start=1 SHALL be stored as shadow slot 0, set slot=1, and move to RECV.
REQ-015 In RECV, a beat with frame_start=0 SHALL be stored in shadow slot `slot`, and slot SHALL increment.
REQ-016 On acceptance of slot NCH-1: at the same edge, z SHALL load all NCH samples, z_valid SHALL pulse the next cycle, and the FSM SHALL return to HUNT.
REQ-017 Back-to-back frames, with frame_start on the beat after slot NCH-1, SHALL be accepted with no idle cycle.
REQ-018 In RECV, a beat with frame_start=1 SHALL pulse sync_err, discard the partial frame, store the beat as slot 0, and set slot=1.
REQ-019 Cycles with d_valid=0 SHALL hold all state; gaps of any length inside a frame are legal.
REQ-020 z SHALL change only on frame completion and SHALL hold its value otherwise.
REQ-021 z_valid and sync_err SHALL never be high for more than one consecutive cycle per event.
REQ-022 Latency: z_valid SHALL be high exactly 1 cycle after the clock edge that accepts slot NCH-1.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock, set FSM=HUNT, slot=0, z=0, z_valid=0, and sync_err=0, and clear shadow storage.
REQ-024 Reset mid-frame SHALL drop the partial frame; after rst_n rises, the first beat is handled as in HUNT.
REQ-025 The release of rst_n SHALL be treated as synchronous to clk; the first accepted beat is the one on the first edge with rst_n=1.

Configuration
REQ-026 Macro TDM_DEMUX_PARITY_EN: when defined, each accepted beat SHALL be checked as ^{d,par}==0.
REQ-027 With TDM_DEMUX_PARITY_EN defined, a parity failure on any beat SHALL pulse sync_err, discard the frame, and return to HUNT; that beat SHALL NOT be stored, even if frame_start=1.
REQ-028 Without TDM_DEMUX_PARITY_EN, port par SHALL be absent, no check SHALL be made, and behaviour SHALL be REQ-012..022 only.

Verification
REQ-029 NCH=4, W=8 frame: beats 8'h11 (fs=1), 8'h22, 8'h33, 8'h44 -> z=32'h44332211, z_valid pulses once, sync_err=0.
REQ-030 The same frame with 3 idle d_valid=0 cycles between each beat -> identical z, and z_valid pulses 1 cycle after the 8'h44 edge.
REQ-031 Beats 8'hAA (fs=1), 8'hBB, then 8'h01 (fs=1), 8'h02, 8'h03, 8'h04 -> sync_err pulses on the 8'h01 beat, then z=32'h04030201, with a single z_valid.
REQ-032 Beats 8'h55 (fs=0) in HUNT, then a valid frame -> the 8'h55 is ignored, no sync_err, and z holds only the frame data.
REQ-033 rst_n low for 1 cycle after slot 2 of a frame -> z=0 and no z_valid; the next full frame 8'h01..8'h04 gives z=32'h04030201.
REQ-034 TDM_DEMUX_PARITY_EN defined: slot 2 sent with wrong par -> sync_err pulse, no z_valid, z unchanged; the next good frame is accepted.
